image_frame_loader: RTL and testbench
=====================================

# image_frame_loader

Upstream feeder for the halftone image converter. Accepts a raster stream of 8-bit grayscale pixels over a valid/ready handshake and assembles a 6×8 frame in a register array. Presents all 48 pixels in parallel, clears the converter with a reset pulse, launches it with a one-cycle `Go`, then holds the frame stable until the converter reports `Done`. Sits between the pixel source (camera/DMA) and the converter's `pixel_1..pixel_48` / `Go` / `reset` inputs.

## Interface
- `N_ROWS`, default 6: frame rows.
- `N_COLS`, default 8: frame columns.
- `PIX_W`, default 8: pixel width.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `LOADER_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pix_in` in `PIX_W`: stream pixel.
- `pix_valid` in 1: `pix_in` valid.
- `sof` in 1: start-of-frame marker; qualified by `pix_valid`.
- `pix_ready` out 1: loader accepts a pixel this cycle.
- `pixel_bus` out `N_ROWS*N_COLS*PIX_W` (384): pixel k (1..48) on bits `[8k-1:8k-8]`. Connects to converter `pixel_k`.
- `conv_reset` out 1: reset to the converter.
- `Go` out 1: converter launch pulse.
- `Done` in 1: converter completion level.
- `busy` out 1: frame handed to the converter and not yet released.
- `frame_err` out 1: sticky flag for a misplaced `sof`.
- `timeout` out 1: sticky watchdog flag.

## Operation
- Transfer occurs when `pix_valid & pix_ready` are both high at a rising edge.
- Pixels arrive in raster order, row-major: transfer n (0..47) writes slot n+1. Row r, column c maps to pixel `(r-1)*8+c`.
- Counter `cnt` runs 0..47.
- States:
  - LOAD: `pix_ready=1`. Each transfer writes the slot and increments `cnt`. The transfer at `cnt==47` resets `cnt` to 0 and moves to CLEAR.
  - CLEAR (2 cycles): `conv_reset=1`, `pix_ready=0`. Then moves to LAUNCH.
  - LAUNCH (1 cycle): `Go=1`. Then moves to WAIT_DONE.
  - WAIT_DONE: `pix_ready=0`, `busy=1`. `pixel_bus` is frozen. `Done==1` moves to LOAD.
- `sof` handling:
  - `sof` on a transfer with `cnt!=0`: the frame restarts. The pixel goes to slot 1, `cnt` becomes 1, and `frame_err` is set.
  - `sof` with `cnt==0`: legal, no effect.
  - A missing `sof` on the first pixel is legal.
- Slots not yet rewritten in a new frame keep their previous-frame values.
- `conv_reset = reset | (state==CLEAR)`. The converter is cleared whenever the loader resets.
- Reset values:
  - state LOAD, `cnt=0`.
  - `pixel_bus=0`.
  - `Go`, `busy`, `frame_err`, `timeout` all 0.
  - `pix_ready=0` while `reset` is high.
- Reset during any state, including mid-load or WAIT_DONE: all of the above apply on the next edge. Partial frames are discarded.

## Timing
- Last pixel accepted at edge t:
  - `conv_reset` is high in cycles t+1 and t+2.
  - `Go` is high in cycle t+3.
  - WAIT_DONE starts at t+4.
- `Done` is sampled only in WAIT_DONE. It is ignored elsewhere, including during CLEAR and LAUNCH, where the converter is being reset.
- `Done` seen at edge u: `pix_ready=1` in cycle u+1. A new frame may then start immediately.
- Minimum frame period is 48 + 3 + converter latency + 1 cycles.
- All outputs except `pix_ready` and `conv_reset` are registered. `pix_ready` and `conv_reset` are decoded from registered state and `reset` only, so there is no combinational path from `pix_valid`.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - An 8-bit cycle counter runs in WAIT_DONE.
  - If `Done` is not seen within `TIMEOUT_CYCLES` cycles of entering WAIT_DONE, the loader sets `timeout` (sticky until `reset`) and returns to LOAD.
  - `Done` arriving on the same edge as expiry counts as success; `timeout` is not set.
- `LOADER_TIMEOUT_EN` undefined:
  - No counter. WAIT_DONE waits indefinitely.
  - `timeout` is tied to 0.

## Test plan
- Checkerboard frame:
  - Stimulus: rows 1–3 = 255×4, 0×4; rows 4–6 = 0×4, 255×4; `pix_valid` held high.
  - Response: `pixel_bus[7:0]=255`, `[39:32]=0`, `[199:192]=0`. `conv_reset` high 2 cycles, then `Go` high exactly 1 cycle, 3 cycles after the last transfer.
- Back-pressure:
  - Stimulus: second frame presented with `pix_valid=1` throughout WAIT_DONE; `Done` raised 40 cycles after `Go`.
  - Response: zero transfers and stable `pixel_bus` during WAIT_DONE. First transfer of frame 2 on the cycle after `Done`.
- Misplaced `sof`:
  - Stimulus: `sof` asserted on transfer 20, value 77.
  - Response: `frame_err=1`, slot 1 = 77. `Go` only after 47 further transfers.
- Reset mid-load:
  - Stimulus: `reset` asserted after 30 transfers.
  - Response: next cycle has `pixel_bus=0`, `cnt=0`, `conv_reset=1`, no `Go`. A full 48-pixel frame is then required before `Go`.
- Timeout (with `LOADER_TIMEOUT_EN`):
  - Stimulus: `Done` held 0.
  - Response: `timeout=1` and `pix_ready=1` 255 cycles into WAIT_DONE.
  - Without the macro, the same stimulus keeps `busy=1` indefinitely.
- Graduated frame:
  - Stimulus: each row = 31, 63, …, 255.
  - Response: `pixel_bus[63:56]=255`, `[383:376]=255`, `[327:320]=31`.

Source files
------------

// File: rtl/image_frame_loader.sv
// image_frame_loader: assembles a raster pixel stream into a parallel frame and hands it to the converter.
// Optional watchdog on the converter handshake is enabled with `define LOADER_TIMEOUT_EN.
module image_frame_loader #(
    parameter int N_ROWS         = 6,
    parameter int N_COLS         = 8,
    parameter int PIX_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PIX_W-1:0]                 pix_in,
    input  logic                             pix_valid,
    input  logic                             sof,
    output logic                             pix_ready,
    output logic [N_ROWS*N_COLS*PIX_W-1:0]   pixel_bus,
    output logic                             conv_reset,
    output logic                             Go,
    input  logic                             Done,
    output logic                             busy,
    output logic                             frame_err,
    output logic                             timeout
);
    localparam int NPIX = N_ROWS * N_COLS;
    localparam int CW = $clog2(NPIX);
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    typedef enum logic [2:0] {LOAD, CLR0, CLR1, LAUNCH, WAIT} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] frame_q [NPIX];
    logic go_q, busy_q, err_q, expire;
    logic xfer, restart;

    assign xfer = pix_valid & pix_ready;
    assign restart = xfer & sof & (cnt_q != '0);
    assign Go = go_q;
    assign busy = busy_q;
    assign frame_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q <= '0;
            go_q <= 1'b0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            go_q <= state_d == LAUNCH;
            busy_q <= state_d == WAIT;
            err_q <= err_q | restart;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            LOAD: if (xfer) begin
                cnt_d = restart ? CW'(1) : (cnt_q == LAST ? '0 : cnt_q + CW'(1));
                state_d = (!restart && cnt_q == LAST) ? CLR0 : LOAD;
            end
            CLR0: state_d = CLR1;
            CLR1: state_d = LAUNCH;
            LAUNCH: state_d = WAIT;
            WAIT: state_d = (Done || expire) ? LOAD : WAIT;
            default: state_d = LOAD;
        endcase
    end

    // Handshake outputs decode only registered state and reset, never pix_valid.
    always_comb begin
        pix_ready = !reset && state_q == LOAD;
        conv_reset = reset || state_q == CLR0 || state_q == CLR1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPIX; i++) frame_q[i] <= '0;
        end else if (xfer) begin
            frame_q[restart ? '0 : cnt_q] <= pix_in;
        end
    end

    for (genvar k = 0; k < NPIX; k++) begin : g_bus
        assign pixel_bus[k*PIX_W +: PIX_W] = frame_q[k];
    end

`ifdef LOADER_TIMEOUT_EN
    logic [7:0] tmr_q;
    logic to_q;
    // Done on the expiry edge wins, so expiry is masked by Done.
    assign expire = state_q == WAIT && !Done && tmr_q == 8'(TIMEOUT_CYCLES - 1);
    assign timeout = to_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q <= '0;
            to_q <= 1'b0;
        end else begin
            tmr_q <= state_q == WAIT ? tmr_q + 8'd1 : 8'd0;
            to_q <= to_q | expire;
        end
    end
`else
    assign expire = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_image_frame_loader.sv
// tb_image_frame_loader: directed tests for the frame loader, one task per scenario.
module tb_image_frame_loader;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   pix_in = '0;
    logic         pix_valid = 1'b0;
    logic         sof = 1'b0;
    logic         pix_ready;
    logic [383:0] pixel_bus;
    logic         conv_reset;
    logic         Go;
    logic         Done = 1'b0;
    logic         busy;
    logic         frame_err;
    logic         timeout;
    logic [383:0] exp_bus = '0;
    int           checks = 0;
    int           errors = 0;

    image_frame_loader dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .pix_ready(pix_ready), .pixel_bus(pixel_bus), .conv_reset(conv_reset), .Go(Go),
        .Done(Done), .busy(busy), .frame_err(frame_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v, input logic s, input int slot);
        int n;
        pix_in = v;
        sof = s;
        pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < 200) begin
            step();
            n++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait: pix_ready=%b required 1", pix_ready);
        end else begin
            step();
            exp_bus[8*slot +: 8] = v;
        end
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy: busy=%b required 1", busy);
        end
    endtask

    task automatic release_done();
        Done = 1'b1;
        step();
        Done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (pix_ready !== 1'b0 || conv_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: ready=%b conv_reset=%b required 0 1", pix_ready, conv_reset);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (pixel_bus !== '0 || Go !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: bus_nz=%b Go=%b busy=%b err=%b to=%b required all 0",
                     |pixel_bus, Go, busy, frame_err, timeout);
        end
        checks++;
        if (pix_ready !== 1'b1 || conv_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b conv_reset=%b required 1 0", pix_ready, conv_reset);
        end
    endtask

    task automatic test_checkerboard();
        for (int n = 0; n < 48; n++)
            push(((n / 8 < 3) == (n % 8 < 4)) ? 8'd255 : 8'd0, n == 0, n);
        pix_valid = 1'b0;
        sof = 1'b0;
        checks++;
        if (conv_reset !== 1'b1 || Go !== 1'b0) begin
            errors++;
            $display("FAIL chk_t1: conv_reset=%b Go=%b required 1 0", conv_reset, Go);
        end
        step();
        checks++;
        if (conv_reset !== 1'b1 || Go !== 1'b0) begin
            errors++;
            $display("FAIL chk_t2: conv_reset=%b Go=%b required 1 0", conv_reset, Go);
        end
        step();
        checks++;
        if (conv_reset !== 1'b0 || Go !== 1'b1) begin
            errors++;
            $display("FAIL chk_t3: conv_reset=%b Go=%b required 0 1", conv_reset, Go);
        end
        step();
        checks++;
        if (Go !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL chk_t4: Go=%b busy=%b required 0 1", Go, busy);
        end
        checks++;
        if (pixel_bus[7:0] !== 8'd255 || pixel_bus[39:32] !== 8'd0 || pixel_bus[199:192] !== 8'd0) begin
            errors++;
            $display("FAIL chk_pix: p1=%0d p5=%0d p25=%0d required 255 0 0",
                     pixel_bus[7:0], pixel_bus[39:32], pixel_bus[199:192]);
        end
        checks++;
        if (pixel_bus !== exp_bus) begin
            errors++;
            $display("FAIL chk_bus: got %h required %h", pixel_bus, exp_bus);
        end
    endtask

    task automatic test_back_pressure();
        int bad;
        bad = 0;
        pix_in = 8'd31;
        sof = 1'b1;
        pix_valid = 1'b1;
        for (int i = 0; i < 39; i++) begin
            if (pix_ready !== 1'b0 || busy !== 1'b1 || pixel_bus !== exp_bus) bad++;
            step();
        end
        Done = 1'b1;
        if (pix_ready !== 1'b0 || pixel_bus !== exp_bus) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles required 0", bad);
        end
        step();
        Done = 1'b0;
        checks++;
        if (pix_ready !== 1'b1 || busy !== 1'b0 || pixel_bus !== exp_bus) begin
            errors++;
            $display("FAIL bp_release: ready=%b busy=%b bus_ok=%b required 1 0 1",
                     pix_ready, busy, pixel_bus === exp_bus);
        end
        step();
        exp_bus[7:0] = 8'd31;
        checks++;
        if (pixel_bus[7:0] !== 8'd31) begin
            errors++;
            $display("FAIL bp_first: p1=%0d required 31", pixel_bus[7:0]);
        end
    endtask

    task automatic test_graduated();
        for (int n = 1; n < 48; n++)
            push(8'(32 * (n % 8 + 1) - 1), 1'b0, n);
        pix_valid = 1'b0;
        wait_busy();
        checks++;
        if (pixel_bus[63:56] !== 8'd255 || pixel_bus[383:376] !== 8'd255 || pixel_bus[327:320] !== 8'd31) begin
            errors++;
            $display("FAIL grad_pix: p8=%0d p48=%0d p41=%0d required 255 255 31",
                     pixel_bus[63:56], pixel_bus[383:376], pixel_bus[327:320]);
        end
        checks++;
        if (pixel_bus !== exp_bus) begin
            errors++;
            $display("FAIL grad_bus: got %h required %h", pixel_bus, exp_bus);
        end
        release_done();
    endtask

    task automatic test_sof();
        for (int n = 0; n < 20; n++)
            push(8'(100 + n), n == 0, n);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL sof_legal: frame_err=%b required 0", frame_err);
        end
        push(8'd77, 1'b1, 0);
        checks++;
        if (frame_err !== 1'b1 || pixel_bus[7:0] !== 8'd77 || pixel_bus[159:152] !== 8'd119) begin
            errors++;
            $display("FAIL sof_restart: err=%b p1=%0d p20=%0d required 1 77 119",
                     frame_err, pixel_bus[7:0], pixel_bus[159:152]);
        end
        for (int n = 1; n < 47; n++)
            push(8'(n + 1), 1'b0, n);
        checks++;
        if (conv_reset !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL sof_count: conv_reset=%b ready=%b required 0 1", conv_reset, pix_ready);
        end
        push(8'd200, 1'b0, 47);
        pix_valid = 1'b0;
        checks++;
        if (conv_reset !== 1'b1) begin
            errors++;
            $display("FAIL sof_done: conv_reset=%b required 1", conv_reset);
        end
        wait_busy();
        checks++;
        if (pixel_bus !== exp_bus) begin
            errors++;
            $display("FAIL sof_bus: got %h required %h", pixel_bus, exp_bus);
        end
        release_done();
    endtask

    task automatic test_reset_midload();
        for (int n = 0; n < 30; n++)
            push(8'(n + 1), n == 0, n);
        pix_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (conv_reset !== 1'b1 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: conv_reset=%b ready=%b required 1 0", conv_reset, pix_ready);
        end
        step();
        reset = 1'b0;
        exp_bus = '0;
        #1;
        checks++;
        if (pixel_bus !== '0 || Go !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_clear: bus_nz=%b Go=%b err=%b busy=%b required 0 0 0 0",
                     |pixel_bus, Go, frame_err, busy);
        end
        for (int n = 0; n < 47; n++)
            push(8'(n + 50), 1'b0, n);
        checks++;
        if (conv_reset !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_count: conv_reset=%b ready=%b required 0 1", conv_reset, pix_ready);
        end
        push(8'd9, 1'b0, 47);
        pix_valid = 1'b0;
        wait_busy();
        checks++;
        if (pixel_bus !== exp_bus) begin
            errors++;
            $display("FAIL rst_bus: got %h required %h", pixel_bus, exp_bus);
        end
    endtask

    task automatic test_timeout();
`ifdef LOADER_TIMEOUT_EN
        for (int i = 0; i < 254; i++) step();
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_early: busy=%b timeout=%b required 1 0", busy, timeout);
        end
        step();
        checks++;
        if (timeout !== 1'b1 || pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_expire: timeout=%b ready=%b busy=%b required 1 1 0", timeout, pix_ready, busy);
        end
`else
        for (int i = 0; i < 300; i++) step();
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL to_hold: busy=%b timeout=%b ready=%b required 1 0 0", busy, timeout, pix_ready);
        end
        release_done();
        checks++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_release: ready=%b busy=%b required 1 0", pix_ready, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_checkerboard();
        test_back_pressure();
        test_graduated();
        test_sof();
        test_reset_midload();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
